// File: rtl/square_motion_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : square_motion_ctrl
// Description : Sequences a moving square on the VGA framebuffer plot port.
//               Each frame tick erases the square at its old position,
//               moves it by SPEED pixels in the latched direction (clamped to
//               the screen edges) and redraws it at the new position.
// Revision    : 1.0 - initial release
// ============================================================================
module square_motion_ctrl #(
    parameter int         WIDTH     = 640,
    parameter int         HEIGHT    = 480,
    parameter int         SIZE      = 4,
    parameter int         SPEED     = 2,
    parameter int         START_X   = 0,
    parameter int         START_Y   = 0,
    parameter logic [8:0] FG_COLOUR = 9'b111_000_000,
    parameter logic [8:0] BG_COLOUR = 9'b000_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       frame_tick,
    input  logic [1:0] dir,
    input  logic       plot_ready,
    output logic       plot_valid,
    output logic [9:0] plot_x,
    output logic [8:0] plot_y,
    output logic [8:0] plot_colour,
    output logic       busy,
    output logic       frame_done,
    output logic [9:0] pos_x,
    output logic [8:0] pos_y,
    output logic [7:0] missed_frames
);

    // Pixel counters cover 0..15 (SIZE up to 16).
    localparam int          c_CNT_W   = 5;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(SIZE - 1);

    localparam logic [1:0]  c_ST_DRAW  = 2'd0;
    localparam logic [1:0]  c_ST_WAIT  = 2'd1;
    localparam logic [1:0]  c_ST_ERASE = 2'd2;
    localparam logic [1:0]  c_ST_MOVE  = 2'd3;

    localparam logic [1:0]  c_DIR_RIGHT = 2'd0;
    localparam logic [1:0]  c_DIR_DOWN  = 2'd1;
    localparam logic [1:0]  c_DIR_LEFT  = 2'd2;

    // Position arithmetic is one bit wider than the position registers so
    // the sum can never wrap before it is clamped.
    localparam logic [10:0] c_MAX_X   = 11'(WIDTH - SIZE);
    localparam logic [9:0]  c_MAX_Y   = 10'(HEIGHT - SIZE);
    localparam logic [10:0] c_SPEED_X = 11'(SPEED);
    localparam logic [9:0]  c_SPEED_Y = 10'(SPEED);

    logic [1:0]         state_q, state_d;
    logic [c_CNT_W-1:0] cx_q, cx_d;
    logic [c_CNT_W-1:0] cy_q, cy_d;
    logic [9:0]         pos_x_q, pos_x_d;
    logic [8:0]         pos_y_q, pos_y_d;
    logic [1:0]         dir_q, dir_d;
    logic               pending_q, pending_d;
    logic [7:0]         missed_frames_q, missed_frames_d;
    logic               frame_done_q, frame_done_d;

    logic               w_walking;
    logic               w_xfer;
    logic               w_last_col;
    logic               w_last_pix;
    logic [10:0]        w_sum_x;
    logic [10:0]        w_dif_x;
    logic [9:0]         w_sum_y;
    logic [9:0]         w_dif_y;

    assign w_walking  = (state_q == c_ST_DRAW) || (state_q == c_ST_ERASE);
    assign w_xfer     = w_walking && plot_ready;
    assign w_last_col = (cx_q == c_LAST);
    assign w_last_pix = w_last_col && (cy_q == c_LAST);

    assign w_sum_x = {1'b0, pos_x_q} + c_SPEED_X;
    assign w_dif_x = {1'b0, pos_x_q} - c_SPEED_X;
    assign w_sum_y = {1'b0, pos_y_q} + c_SPEED_Y;
    assign w_dif_y = {1'b0, pos_y_q} - c_SPEED_Y;

    // Pixel address and colour come straight from registered state, so they
    // stay frozen for as long as the adapter stalls a request.
    assign plot_valid    = w_walking;
    assign plot_x        = pos_x_q + {{(10 - c_CNT_W){1'b0}}, cx_q};
    assign plot_y        = pos_y_q + {{(9 - c_CNT_W){1'b0}}, cy_q};
    assign plot_colour   = (state_q == c_ST_DRAW) ? FG_COLOUR : BG_COLOUR;
    assign busy          = (state_q != c_ST_WAIT);
    assign frame_done    = frame_done_q;
    assign pos_x         = pos_x_q;
    assign pos_y         = pos_y_q;
    assign missed_frames = missed_frames_q;

    // Next-state logic: pixel walk, tick buffering and clamped move.
    always_comb begin
        state_d         = state_q;
        cx_d            = cx_q;
        cy_d            = cy_q;
        pos_x_d         = pos_x_q;
        pos_y_d         = pos_y_q;
        dir_d           = dir_q;
        pending_d       = pending_q;
        missed_frames_d = missed_frames_q;
        frame_done_d    = 1'b0;

        // One tick can be buffered while busy; further ones are counted.
        if (enable && frame_tick && (state_q != c_ST_WAIT)) begin
            if (!pending_q) begin
                pending_d = 1'b1;
            end else if (missed_frames_q != 8'hFF) begin
                missed_frames_d = missed_frames_q + 8'd1;
            end
        end

        case (state_q)
            c_ST_DRAW, c_ST_ERASE: begin
                if (w_xfer) begin
                    if (w_last_pix) begin
                        cx_d = '0;
                        cy_d = '0;
                        if (state_q == c_ST_DRAW) begin
                            state_d      = c_ST_WAIT;
                            frame_done_d = 1'b1;
                        end else begin
                            state_d = c_ST_MOVE;
                        end
                    end else if (w_last_col) begin
                        cx_d = '0;
                        cy_d = cy_q + 1'b1;
                    end else begin
                        cx_d = cx_q + 1'b1;
                    end
                end
            end
            c_ST_WAIT: begin
                if ((frame_tick || pending_q) && enable) begin
                    dir_d     = dir;
                    pending_d = 1'b0;
                    state_d   = c_ST_ERASE;
                end
            end
            default: begin
                case (dir_q)
                    c_DIR_RIGHT: pos_x_d = (w_sum_x > c_MAX_X) ? c_MAX_X[9:0] : w_sum_x[9:0];
                    c_DIR_DOWN:  pos_y_d = (w_sum_y > c_MAX_Y) ? c_MAX_Y[8:0] : w_sum_y[8:0];
                    c_DIR_LEFT:  pos_x_d = ({1'b0, pos_x_q} < c_SPEED_X) ? '0 : w_dif_x[9:0];
                    default:     pos_y_d = ({1'b0, pos_y_q} < c_SPEED_Y) ? '0 : w_dif_y[8:0];
                endcase
                state_d = c_ST_DRAW;
            end
        endcase
    end

    // State registers; reset restarts the draw at the start position.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q         <= c_ST_DRAW;
            cx_q            <= '0;
            cy_q            <= '0;
            pos_x_q         <= 10'(START_X);
            pos_y_q         <= 9'(START_Y);
            dir_q           <= '0;
            pending_q       <= 1'b0;
            missed_frames_q <= '0;
            frame_done_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            cx_q            <= cx_d;
            cy_q            <= cy_d;
            pos_x_q         <= pos_x_d;
            pos_y_q         <= pos_y_d;
            dir_q           <= dir_d;
            pending_q       <= pending_d;
            missed_frames_q <= missed_frames_d;
            frame_done_q    <= frame_done_d;
        end
    end

endmodule
`default_nettype wire

// File: doc/square_motion_ctrl.md
Name: square_motion_ctrl

Overview:
Sequences the moving square on the VGA framebuffer plot port. On each frame tick it erases the square at its old position, computes the new position from direction and speed with edge clamping, and redraws it. It sits between the game/input logic and the VGA adapter's pixel-write interface, and is the only writer of the square's pixels.

Parameters:
WIDTH, 640, screen width in pixels
HEIGHT, 480, screen height in pixels
SIZE, 4, square side in pixels (1..16)
SPEED, 2, pixels moved per frame tick
START_X, 0, x position after reset (0..WIDTH-SIZE)
START_Y, 0, y position after reset (0..HEIGHT-SIZE)
FG_COLOUR, 9'b111_000_000, square colour {R[2:0],G[2:0],B[2:0]}
BG_COLOUR, 9'b000_000_000, erase colour

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-high reset
enable  in  1  1 = act on frame ticks; 0 = ignore ticks
frame_tick  in  1  one-cycle pulse per displayed frame
dir  in  2  0 right, 1 down, 2 left, 3 up; sampled when a frame update starts
plot_ready  in  1  adapter accepts the current pixel
plot_valid  out  1  pixel write request
plot_x  out  10  pixel x
plot_y  out  9  pixel y
plot_colour  out  9  pixel colour {R,G,B}
busy  out  1  high in every state except WAIT
frame_done  out  1  one-cycle pulse on entering WAIT after a DRAW
pos_x  out  10  current square x (top-left)
pos_y  out  9  current square y (top-left)
missed_frames  out  8  saturating count of dropped ticks

Behaviour:
- Reset (async, takes effect immediately):
  - state=DRAW, pixel counter=0.
  - pos_x=START_X, pos_y=START_Y.
  - pending=0, missed_frames=0, frame_done=0.
  - plot_valid=1 from the first clock after release.
- States and transitions:
  - DRAW: emit SIZE*SIZE pixels at (pos_x+cx, pos_y+cy) with FG_COLOUR. Row-major order: cx is the inner loop, 0..SIZE-1. When the last pixel transfers, go to WAIT and pulse frame_done for one cycle.
  - WAIT: plot_valid=0, busy=0. Start an update if (frame_tick|pending)&enable: latch dir, clear pending, go to ERASE.
  - ERASE: same pixel walk at the old position with BG_COLOUR. After the last transfer, go to MOVE.
  - MOVE: one cycle, plot_valid=0; update pos; then DRAW.
- Transfer rule:
  - A pixel transfers on a clock edge where plot_valid & plot_ready.
  - plot_x/plot_y/plot_colour are held stable while plot_valid=1 and plot_ready=0.
  - The pixel counter advances only on a transfer.
- Latency: with plot_ready tied to 1, a tick in WAIT gives ERASE with plot_valid=1 on the next cycle. busy lasts 2*SIZE*SIZE+1 cycles, and frame_done pulses on the cycle WAIT is entered.
- Move arithmetic (unsigned, clamped, never wraps):
  - right: x = min(x+SPEED, WIDTH-SIZE)
  - left: x = (x<SPEED) ? 0 : x-SPEED
  - down: y = min(y+SPEED, HEIGHT-SIZE)
  - up: y = (y<SPEED) ? 0 : y-SPEED
  - Compute intermediate sums one bit wider than the position so there is no overflow.
  - At the edge the square is still erased and redrawn at the same position.
- Tick while busy (state != WAIT), with enable=1:
  - pending=0: set pending=1.
  - pending=1: drop the tick and increment missed_frames, saturating at 255.
  - The pending tick is serviced on the first WAIT cycle.
- enable=0: ticks neither start an update nor set pending, and missed_frames does not change. An update already in progress completes.
- A tick arriving on the same cycle the block enters WAIT sets pending and is serviced on the next cycle.
- Reset mid-operation: abort immediately; the partial square is left in the framebuffer, and the DRAW at the start position is redone.

Test Plan:
- Reset release, plot_ready=1 -> 16 pixels (0,0),(1,0)..(3,3) with colour 9'h1C0 on 16 consecutive cycles; frame_done on cycle 17; busy=0.
- In WAIT, dir=0, one tick -> 16 erase pixels at x 0..3, colour 0; 1 MOVE cycle; 16 draw pixels at x 2..5; pos_x=2.
- START_X=634, dir=0, two ticks -> pos_x=636 after the first, 636 after the second (redrawn in place). Separately, dir=3 from pos_y=1 -> pos_y=0.
- plot_ready pattern 1,0,0,1 during DRAW -> outputs frozen during the stall cycles; pixel order unchanged; exactly 16 transfers.
- Three ticks during ERASE -> pending serviced immediately after frame_done; missed_frames=2. With enable=0, a tick in WAIT -> no activity.
- Assert reset after the 5th DRAW pixel -> outputs return to reset values immediately; the full 16-pixel DRAW restarts at START_X/START_Y.
